// File: rtl/thor2021_ins_bundler_pkg.sv
// -----------------------------------------------------------------------------
// thor2021_ins_bundler_pkg
// Shared types and constants for the fetch-to-decode instruction bundler.
//   Instruction   : one 48-bit parcel
//   InsBundle     : {ir, xir, pc, pfx} as queued for decode
//   NOP_INSN      : filler for xir when no prefix is attached
//   is_exi()      : true for the immediate-extension prefix opcodes
// -----------------------------------------------------------------------------
package thor2021_ins_bundler_pkg;

    localparam int BUNDLE_PCW = 32;

    typedef logic [47:0] Instruction;
    typedef logic [6:0]  opcode_t;

    // Immediate-extension prefixes and the canonical no-op.
    localparam opcode_t OP_EXI7  = 7'h50;
    localparam opcode_t OP_EXI23 = 7'h51;
    localparam opcode_t OP_EXI41 = 7'h52;
    localparam opcode_t OP_NOP   = 7'h3F;

    localparam Instruction NOP_INSN = {41'd0, OP_NOP};

    typedef struct packed {
        Instruction              ir;
        Instruction              xir;
        logic [BUNDLE_PCW-1:0]   pc;
        logic                    pfx;
    } InsBundle;

    function automatic opcode_t opcode_of(input Instruction insn);
        return insn[6:0];
    endfunction

    function automatic logic is_exi(input opcode_t op);
        return (op == OP_EXI7) || (op == OP_EXI23) || (op == OP_EXI41);
    endfunction

endpackage

// File: rtl/thor2021_ins_bundler_if.sv
// -----------------------------------------------------------------------------
// thor2021_ins_bundler_if
// Fetch-side and decode-side handshake signals of the instruction bundler.
//   in_*   : parcel stream from fetch (valid/ready, ir, pc)
//   out_*  : bundle stream to decode (valid/ready, ir, xir, pc, pfx)
//   pfx_err_o : one-cycle pulse on a prefix arriving over a pending prefix
// Modports: slave = the bundler, master = the fetch/decode environment.
// -----------------------------------------------------------------------------
interface thor2021_ins_bundler_if
    import thor2021_ins_bundler_pkg::*;
#(
    parameter int PCW = BUNDLE_PCW
);
    logic             in_valid_i;
    logic             in_ready_o;
    Instruction       in_ir_i;
    logic [PCW-1:0]   in_pc_i;

    logic             out_valid_o;
    logic             out_ready_i;
    Instruction       out_ir_o;
    Instruction       out_xir_o;
    logic [PCW-1:0]   out_pc_o;
    logic             out_pfx_o;

    logic             pfx_err_o;

    modport slave (
        input  in_valid_i, in_ir_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ir_o, out_xir_o, out_pc_o, out_pfx_o,
               pfx_err_o
    );

    modport master (
        output in_valid_i, in_ir_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ir_o, out_xir_o, out_pc_o, out_pfx_o,
               pfx_err_o
    );

endinterface

// File: rtl/thor2021_ins_bundler_fifo.sv
// -----------------------------------------------------------------------------
// thor2021_sync_fifo
// Single-clock FIFO with synchronous reset and clear. When empty, dout holds
// the last entry read (RST_VAL after reset) so downstream sees stable data.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear of pointers and count
//   wr, din      : write request / data (ignored when full)
//   rd, dout     : read request (ignored when empty) / head data
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module thor2021_sync_fifo #(
    parameter int               WID     = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WID-1:0]   RST_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wr,
    input  logic [WID-1:0]           din,
    input  logic                     rd,
    output logic [WID-1:0]           dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WID-1:0]  r_mem [DEPTH];
    logic [WID-1:0]  r_last;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_wr;
    logic            w_rd;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = wr && !full;
    assign w_rd  = rd && !empty;

    // NOTE: the storage array has no reset; every slot is written before the
    // read pointer can reach it, so resetting it would only cost flops.
    always_ff @(posedge clk_i) begin
        if (w_wr && !clr_i) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= RST_VAL;
        end else begin
            // A read in a clear cycle still hands its entry to the consumer.
            if (w_rd) begin
                r_last <= r_mem[r_rd_ptr];
            end
            if (clr_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // Pointers are log2(DEPTH) bits and wrap naturally.
                if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_wr, w_rd})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign dout  = empty ? r_last : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/thor2021_ins_bundler.sv
// -----------------------------------------------------------------------------
// thor2021_ins_bundler
// Sits between fetch/align and decode. Absorbs EXI7/EXI23/EXI41 prefixes and
// attaches the pending one as xir to the next real instruction, then queues
// the resulting bundle for decode.
//   clk_i   : clock
//   rst_i   : synchronous reset, active high (wins over flush_i)
//   flush_i : drop queued bundles and any pending prefix (redirect)
//   bus     : slave side of thor2021_ins_bundler_if (fetch in, decode out,
//             pfx_err_o pulse)
// -----------------------------------------------------------------------------
module thor2021_ins_bundler
    import thor2021_ins_bundler_pkg::*;
#(
    parameter int DEPTH = 4,                 // power of 2, >= 2
    parameter int PCW   = BUNDLE_PCW         // must match BUNDLE_PCW
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    thor2021_ins_bundler_if.slave   bus
);
    localparam InsBundle RST_BUNDLE = '{ir: NOP_INSN, xir: NOP_INSN, pc: '0, pfx: 1'b0};

    Instruction          r_pfx_ir;
    logic [PCW-1:0]      r_pfx_pc;
    logic                r_pfx_v;
    logic                r_pfx_err;

    logic                w_accept;
    logic                w_is_pfx;
    logic                w_enq;
    logic                w_full;
    logic                w_empty;
    logic [$clog2(DEPTH):0] w_unused_count;
    InsBundle            w_bundle;
    InsBundle            w_head;

    // Ready depends on registered occupancy only, never on out_ready_i.
    assign bus.in_ready_o = !rst_i && !flush_i && !w_full;
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;
    assign w_is_pfx       = is_exi(opcode_of(bus.in_ir_i));
    assign w_enq          = w_accept && !w_is_pfx;

    always_comb begin
        w_bundle.ir  = bus.in_ir_i;
        w_bundle.xir = r_pfx_v ? r_pfx_ir : NOP_INSN;
        w_bundle.pc  = r_pfx_v ? r_pfx_pc : bus.in_pc_i;
        w_bundle.pfx = r_pfx_v;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pfx_ir  <= NOP_INSN;
            r_pfx_pc  <= '0;
            r_pfx_v   <= 1'b0;
            r_pfx_err <= 1'b0;
        end else begin
            // No parcel is accepted during flush, so this is 0 then as well.
            r_pfx_err <= w_accept && w_is_pfx && r_pfx_v;
            if (flush_i) begin
                r_pfx_v <= 1'b0;
            end else if (w_accept) begin
                if (w_is_pfx) begin
                    // A second prefix replaces the word but keeps the first
                    // prefix's pc as the restart point.
                    r_pfx_ir <= bus.in_ir_i;
                    if (!r_pfx_v) begin
                        r_pfx_pc <= bus.in_pc_i;
                    end
                    r_pfx_v <= 1'b1;
                end else begin
                    r_pfx_v <= 1'b0;
                end
            end
        end
    end

    thor2021_sync_fifo #(
        .WID     ($bits(InsBundle)),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_BUNDLE)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .wr    (w_enq),
        .din   (w_bundle),
        .rd    (bus.out_ready_i),
        .dout  (w_head),
        .count (w_unused_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.out_valid_o = !w_empty;
    assign bus.out_ir_o    = w_head.ir;
    assign bus.out_xir_o   = w_head.xir;
    assign bus.out_pc_o    = w_head.pc;
    assign bus.out_pfx_o   = w_head.pfx;
    assign bus.pfx_err_o   = r_pfx_err;

endmodule

// File: tb/tb_thor2021_ins_bundler.sv
// -----------------------------------------------------------------------------
// tb_thor2021_ins_bundler
// Directed scenarios followed by randomized fetch/decode traffic, all checked
// against a queue-based reference model of the bundler's behaviour.
// -----------------------------------------------------------------------------
module tb_thor2021_ins_bundler;
    import thor2021_ins_bundler_pkg::*;

    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    localparam opcode_t OP_ADDI  = 7'h04;
    localparam opcode_t OP_ADDIL = 7'h14;
    localparam opcode_t OP_ORIL  = 7'h19;

    typedef struct {
        logic [47:0]    ir;
        logic [47:0]    xir;
        logic [PCW-1:0] pc;
        logic           pfx;
    } mb_t;

    logic clk;
    logic rst_i;
    logic flush_i;

    thor2021_ins_bundler_if #(.PCW(PCW)) bus ();

    thor2021_ins_bundler #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    mb_t            m_q[$];
    mb_t            m_last;
    logic           m_pend;
    logic [47:0]    m_pend_ir;
    logic [PCW-1:0] m_pend_pc;
    logic           m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [47:0] mk(input opcode_t op, input logic [40:0] hi);
        return {hi, op};
    endfunction

    function automatic logic model_is_prefix(input logic [47:0] w);
        opcode_t op;
        op = w[6:0];
        return op == OP_EXI7 || op == OP_EXI23 || op == OP_EXI41;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last    = '{ir: NOP_INSN, xir: NOP_INSN, pc: '0, pfx: 1'b0};
        m_pend    = 1'b0;
        m_pend_ir = '0;
        m_pend_pc = '0;
        m_err     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        flush_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_ir_i     = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_out_ir", 64'(bus.out_ir_o), 64'(NOP_INSN));
        check("rst_out_xir", 64'(bus.out_xir_o), 64'(NOP_INSN));
        check("rst_out_pc", 64'(bus.out_pc_o), 64'd0);
        check("rst_out_pfx", 64'(bus.out_pfx_o), 64'd0);
        check("rst_pfx_err", 64'(bus.pfx_err_o), 64'd0);
        rst_i = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model across the edge.
    task automatic step(input logic v, input logic [47:0] ir, input logic [PCW-1:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        logic exp_rdy;
        mb_t  exp_head;
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.in_ir_i     = ir;
        bus.in_pc_i     = pc;
        bus.out_ready_i = ordy;
        flush_i         = fl;
        #1;
        exp_rdy  = !fl && (m_q.size() < DEPTH);
        exp_head = (m_q.size() != 0) ? m_q[0] : m_last;
        check("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid_o), 64'(m_q.size() != 0));
        check("out_ir", 64'(bus.out_ir_o), 64'(exp_head.ir));
        check("out_xir", 64'(bus.out_xir_o), 64'(exp_head.xir));
        check("out_pc", 64'(bus.out_pc_o), 64'(exp_head.pc));
        check("out_pfx", 64'(bus.out_pfx_o), 64'(exp_head.pfx));
        check("pfx_err", 64'(bus.pfx_err_o), 64'(m_err));
        acc = v && exp_rdy;
        @(posedge clk);
        m_err = 1'b0;
        if (ordy && m_q.size() != 0) m_last = m_q.pop_front();
        if (fl) begin
            m_q.delete();
            m_pend = 1'b0;
        end else if (acc) begin
            if (model_is_prefix(ir)) begin
                if (m_pend) m_err = 1'b1;
                else        m_pend_pc = pc;
                m_pend    = 1'b1;
                m_pend_ir = ir;
            end else begin
                m_q.push_back('{ir: ir, xir: m_pend ? m_pend_ir : NOP_INSN,
                                pc: m_pend ? m_pend_pc : pc, pfx: m_pend});
                m_pend = 1'b0;
            end
        end
    endtask

    initial begin
        logic           acc;
        logic [47:0]    words[6];
        int             idx;
        logic           cur_v;
        logic [47:0]    cur_ir;
        logic [PCW-1:0] cur_pc;
        logic           ordy;
        logic           fl;

        model_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_ir_i     = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;

        // 1. Reset
        do_reset();
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // 2. Plain instruction
        step(1'b1, mk(OP_ADDI, 41'h1_2345), 32'h100, 1'b1, 1'b0, acc);
        #1;
        check("plain_valid", 64'(bus.out_valid_o), 64'd1);
        check("plain_ir", 64'(bus.out_ir_o), 64'(mk(OP_ADDI, 41'h1_2345)));
        check("plain_xir", 64'(bus.out_xir_o), 64'(NOP_INSN));
        check("plain_pc", 64'(bus.out_pc_o), 64'h100);
        check("plain_pfx", 64'(bus.out_pfx_o), 64'd0);

        // 3. Prefixed instruction
        step(1'b1, mk(OP_EXI23, 41'h0_BEEF), 32'h200, 1'b1, 1'b0, acc);
        #1;
        check("pfx_alone_no_bundle", 64'(bus.out_valid_o), 64'd0);
        step(1'b1, mk(OP_ADDIL, 41'h7_0001), 32'h206, 1'b1, 1'b0, acc);
        #1;
        check("pfx_ir", 64'(bus.out_ir_o), 64'(mk(OP_ADDIL, 41'h7_0001)));
        check("pfx_xir", 64'(bus.out_xir_o), 64'(mk(OP_EXI23, 41'h0_BEEF)));
        check("pfx_pc", 64'(bus.out_pc_o), 64'h200);
        check("pfx_flag", 64'(bus.out_pfx_o), 64'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // 4. Back-pressure: 6 offered, queue holds 4, then drain
        for (int i = 0; i < 6; i++) words[i] = mk(OP_ADDI, 41'(i + 41'h10));
        idx = 0;
        repeat (6) begin
            step(1'b1, words[idx], 32'h500 + 32'(6 * idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        #1;
        check("bp_full_ready", 64'(bus.in_ready_o), 64'd0);
        check("bp_head_ir", 64'(bus.out_ir_o), 64'(words[0]));
        for (int c = 0; c < 20; c++) begin
            if (idx < 6) begin
                step(1'b1, words[idx], 32'h500 + 32'(6 * idx), 1'b1, 1'b0, acc);
                if (acc) idx++;
            end else begin
                step(1'b0, '0, '0, 1'b1, 1'b0, acc);
            end
        end
        check("bp_all_accepted", 64'(idx), 64'd6);

        // 5. Double prefix
        step(1'b1, mk(OP_EXI7, 41'h11), 32'h300, 1'b1, 1'b0, acc);
        step(1'b1, mk(OP_EXI41, 41'h1_FFFF_FFFF), 32'h306, 1'b1, 1'b0, acc);
        #1;
        check("dbl_err_pulse", 64'(bus.pfx_err_o), 64'd1);
        step(1'b1, mk(OP_ORIL, 41'h33), 32'h30C, 1'b0, 1'b0, acc);
        #1;
        check("dbl_err_once", 64'(bus.pfx_err_o), 64'd0);
        check("dbl_ir", 64'(bus.out_ir_o), 64'(mk(OP_ORIL, 41'h33)));
        check("dbl_xir", 64'(bus.out_xir_o), 64'(mk(OP_EXI41, 41'h1_FFFF_FFFF)));
        check("dbl_pc", 64'(bus.out_pc_o), 64'h300);

        // 6. Flush discards queue and pending prefix
        step(1'b1, mk(OP_ADDI, 41'h21), 32'h3A0, 1'b0, 1'b0, acc);
        step(1'b1, mk(OP_ADDI, 41'h22), 32'h3A6, 1'b0, 1'b0, acc);
        step(1'b1, mk(OP_EXI7, 41'h23), 32'h3AC, 1'b0, 1'b0, acc);
        step(1'b1, mk(OP_ADDI, 41'h24), 32'h3B2, 1'b0, 1'b1, acc);
        step(1'b1, mk(OP_ADDI, 41'h25), 32'h400, 1'b0, 1'b0, acc);
        #1;
        check("flush_valid", 64'(bus.out_valid_o), 64'd1);
        check("flush_ir", 64'(bus.out_ir_o), 64'(mk(OP_ADDI, 41'h25)));
        check("flush_xir", 64'(bus.out_xir_o), 64'(NOP_INSN));
        check("flush_pc", 64'h400, 64'(bus.out_pc_o));
        check("flush_pfx", 64'(bus.out_pfx_o), 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // 7. Randomized traffic with a fetch unit that holds a parcel until taken
        cur_v  = 1'b0;
        cur_ir = '0;
        cur_pc = 32'h1000;
        for (int c = 0; c < 800; c++) begin
            if (!cur_v && $urandom_range(9) < 7) begin
                cur_v  = 1'b1;
                cur_pc = cur_pc + 32'd6;
                cur_ir = {16'($urandom), $urandom};
                if ($urandom_range(3) == 0) begin
                    case ($urandom_range(2))
                        0:       cur_ir[6:0] = OP_EXI7;
                        1:       cur_ir[6:0] = OP_EXI23;
                        default: cur_ir[6:0] = OP_EXI41;
                    endcase
                end
            end
            ordy = ($urandom_range(9) < 6);
            fl   = ($urandom_range(49) == 0);
            step(cur_v, cur_ir, cur_pc, ordy, fl, acc);
            if (acc || fl) cur_v = 1'b0;
            if (fl) cur_pc = $urandom & 32'hFFFF_FFF0;
        end
        repeat (DEPTH + 2) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
